jk_reg_bank: RTL and testbench

JK_REG_BANK -- requirements
Module: jk_reg_bank

---
 rtl/jk_pkg.sv | 11 +
 rtl/jk_bit.sv | 20 ++
 rtl/jk_reg_bank.sv | 72 +++++++
 tb/tb_jk_reg_bank.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - mode encodings and types shared by the JK register bank
package jk_pkg;

    typedef enum logic [1:0] {
        MODE_JK = 2'b00,
        MODE_T  = 2'b01,
        MODE_UP = 2'b10,
        MODE_DN = 2'b11
    } mode_e;

endpackage

// File: rtl/jk_bit.sv
// rtl/jk_bit.sv - single-bit JK next-state function
module jk_bit (
    input  logic j,
    input  logic k,
    input  logic q,
    output logic qn
);

    always_comb begin
        qn = q;
        unique case ({j, k})
            2'b00: qn = q;
            2'b01: qn = 1'b0;
            2'b10: qn = 1'b1;
            2'b11: qn = ~q;
            default: qn = q;
        endcase
    end

endmodule

// File: rtl/jk_reg_bank.sv
// rtl/jk_reg_bank.sv - JK/T register bank with up/down count, clear and load
module jk_reg_bank
    import jk_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             srst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             chg
);

    mode_e            mode_s;
    logic [WIDTH-1:0] bit_j;
    logic [WIDTH-1:0] bit_k;
    logic [WIDTH-1:0] jk_q;
    logic [WIDTH-1:0] q_nxt;

    assign mode_s = mode_e'(mode);

    // T mode reuses the JK cell: driving k from j turns {1,1} into toggle, {0,0} into hold
    assign bit_j = j;
    assign bit_k = (mode_s == MODE_T) ? j : k;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_bit u_bit (
            .j  (bit_j[i]),
            .k  (bit_k[i]),
            .q  (q[i]),
            .qn (jk_q[i])
        );
    end

    always_comb begin
        q_nxt = q;
        if (srst) begin
            q_nxt = RST_VAL;
        end else if (load) begin
            q_nxt = d;
        end else if (en) begin
            unique case (mode_s)
                MODE_JK, MODE_T: q_nxt = jk_q;
                MODE_UP:         q_nxt = q + WIDTH'(1);
                MODE_DN:         q_nxt = q - WIDTH'(1);
                default:         q_nxt = q;
            endcase
        end
    end

    assign tc = en & ~srst & ~load &
                (((mode_s == MODE_UP) & (q == '1)) | ((mode_s == MODE_DN) & (q == '0)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q   <= RST_VAL;
            chg <= 1'b0;
        end else begin
            q   <= q_nxt;
            chg <= (q_nxt != q);
        end
    end

endmodule

// File: tb/tb_jk_reg_bank.sv
// tb/tb_jk_reg_bank.sv - directed self-checking bench for jk_reg_bank
module tb_jk_reg_bank;
    import jk_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       srst;
    logic       load;
    logic [7:0] d;
    logic [1:0] mode;
    logic [7:0] j;
    logic [7:0] k;
    logic [7:0] q;
    logic       tc;
    logic       chg;

    int n_cmp = 0;
    int n_err = 0;

    jk_reg_bank #(.WIDTH(8), .RST_VAL(8'h00)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .srst (srst),
        .load (load),
        .d    (d),
        .mode (mode),
        .j    (j),
        .k    (k),
        .q    (q),
        .tc   (tc),
        .chg  (chg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; en = 1'b0; srst = 1'b0; load = 1'b0;
        d = 8'h00; mode = MODE_JK; j = 8'h00; k = 8'h00;
        #2;
        chk("reset_q", q, 8'h00);
        chk("reset_chg", chg, 1'b0);
        chk("reset_tc", tc, 1'b0);
        repeat (2) step();
        rst = 1'b0;

        // async reset between edges while q=5A
        load = 1'b1; d = 8'h5A;
        step();
        chk("load_5a_q", q, 8'h5A);
        chk("load_5a_chg", chg, 1'b1);
        load = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_q", q, 8'h00);
        chk("async_rst_chg", chg, 1'b0);
        #2 rst = 1'b0;

        // JK: toggle low nibble, clear high nibble
        load = 1'b1; d = 8'hF0;
        step();
        chk("load_f0_q", q, 8'hF0);
        load = 1'b0; en = 1'b1; mode = MODE_JK; j = 8'h0F; k = 8'hFF;
        #1 chk("jk_tc", tc, 1'b0);
        step();
        chk("jk_toggle_clear_q", q, 8'h0F);
        chk("jk_toggle_clear_chg", chg, 1'b1);
        j = 8'hF0; k = 8'h00;
        step();
        chk("jk_set_hold_q", q, 8'hFF);
        j = 8'h00; k = 8'h00;
        step();
        chk("jk_hold_q", q, 8'hFF);
        chk("jk_hold_chg", chg, 1'b0);

        // UP with wrap
        load = 1'b1; d = 8'hFE; en = 1'b0;
        step();
        chk("load_fe_q", q, 8'hFE);
        load = 1'b0; en = 1'b1; mode = MODE_UP; j = 8'hA5; k = 8'h5A;
        #1 chk("up_fe_tc", tc, 1'b0);
        step();
        chk("up_ff_q", q, 8'hFF);
        chk("up_ff_chg", chg, 1'b1);
        chk("up_ff_tc", tc, 1'b1);
        step();
        chk("up_00_q", q, 8'h00);
        chk("up_00_chg", chg, 1'b1);
        chk("up_00_tc", tc, 1'b0);
        step();
        chk("up_01_q", q, 8'h01);
        chk("up_01_chg", chg, 1'b1);

        // DN with wrap, mode change same edge
        mode = MODE_DN;
        #1 chk("dn_01_tc", tc, 1'b0);
        step();
        chk("dn_00_q", q, 8'h00);
        chk("dn_00_tc", tc, 1'b1);
        en = 1'b0;
        #1 chk("dn_tc_en0", tc, 1'b0);
        en = 1'b1;
        step();
        chk("dn_ff_q", q, 8'hFF);
        chk("dn_ff_tc", tc, 1'b0);
        chk("dn_ff_chg", chg, 1'b1);

        // srst beats load and count
        load = 1'b1; d = 8'h10; en = 1'b0;
        step();
        chk("load_10_q", q, 8'h10);
        srst = 1'b1; load = 1'b1; d = 8'h33; mode = MODE_UP; en = 1'b1;
        #1 chk("srst_tc", tc, 1'b0);
        step();
        chk("srst_q", q, 8'h00);
        chk("srst_chg", chg, 1'b1);
        step();
        chk("srst_again_q", q, 8'h00);
        chk("srst_again_chg", chg, 1'b0);
        srst = 1'b0; d = 8'h3C;
        step();
        chk("load_en_q", q, 8'h3C);
        step();
        chk("load_same_chg", chg, 1'b0);

        // T mode: en=0 holds, en=1 toggles where j=1, k ignored
        load = 1'b0; en = 1'b0; mode = MODE_T; j = 8'hFF; k = 8'h00;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("t_hold%0d_q", i), q, 8'h3C);
            chk($sformatf("t_hold%0d_chg", i), chg, 1'b0);
        end
        en = 1'b1;
        #1 chk("t_tc", tc, 1'b0);
        step();
        chk("t_invert_q", q, 8'hC3);
        chk("t_invert_chg", chg, 1'b1);
        j = 8'h0F; k = 8'hF0;
        step();
        chk("t_partial_q", q, 8'hCC);

        // reset mid-count restarts from RST_VAL
        mode = MODE_UP;
        step();
        chk("up_cd_q", q, 8'hCD);
        #2 rst = 1'b1;
        #1 chk("midcount_rst_q", q, 8'h00);
        step();
        chk("rst_held_q", q, 8'h00);
        chk("rst_held_chg", chg, 1'b0);
        rst = 1'b0;
        step();
        chk("restart_q", q, 8'h01);
        chk("restart_chg", chg, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
